hdma_xfer: RTL

HDMA_XFER -- requirements
Module: hdma_xfer

---
 rtl/hdma_xfer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hdma_xfer.sv
// hdma_xfer: two-stage copy engine that moves bytes from the CPU source bus
// into VRAM while the HDMA/GDMA controller owns the bus.
//
// Pipeline (every step is gated by ce):
//   s1 : latch source/target/bank whenever hdma_rd is high; drive mem_addr/mem_rd
//   s2 : capture mem_din plus the s1 target/bank one ce later
//   wr : pulse vram_we when s2 holds an in-range target that differs from the
//        last written target, so a byte held for 2 or 4 ce cycles is written once
//
// The FSM (IDLE/RUN/DRAIN) keeps the CPU stalled until the pipeline has
// flushed. DRAIN lasts two ce cycles unless hdma_rd comes back, which returns
// the FSM to RUN.
//
// Handshake: the source side has no back-pressure. A byte is offered on every
// ce where hdma_rd=1. The source bus returns mem_din for the address on
// mem_addr/mem_rd in time for the next ce. vram_we is valid for exactly one
// ce period and has no ready.
//
// Build option: define HDMA_XFER_SRC_REMAP_EN to fold source addresses
// 0xE000-0xFFFF (echo RAM) onto 0xA000-0xBFFF by clearing bit 14. Without it,
// the source address is passed through unchanged.
//
// state_dbg exposes the FSM encoding: 0=IDLE, 1=RUN, 2=DRAIN.

module hdma_xfer (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        hdma_active,
  input  logic        hdma_rd,
  input  logic [15:0] hdma_source_addr,
  input  logic [15:0] hdma_target_addr,
  input  logic        vram_bank,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_din,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        vram_we,
  output logic        cpu_stall,
  output logic [11:0] bytes_done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic        drain_cnt;

  // stage 1
  logic        s1_valid;
  logic [15:0] s1_tgt;
  logic        s1_bank;

  // stage 2
  logic        s2_valid;
  logic [15:0] s2_tgt;
  logic        s2_bank;
  logic [7:0]  s2_data;

  // write bookkeeping
  logic        active_q;
  logic        written_any;
  logic [15:0] last_tgt;

  logic        active_rise;
  logic        s2_in_range;
  logic        first_write;
  logic        wr_now;

  function automatic logic [15:0] remap_src(input logic [15:0] a);
`ifdef HDMA_XFER_SRC_REMAP_EN
    if (a[15:13] == 3'b111) begin
      return {a[15], 1'b0, a[13:0]};
    end
    return a;
`else
    return a;
`endif
  endfunction

  // A new DMA session starts on each rising edge of hdma_active (seen at a ce).
  assign active_rise = hdma_active & ~active_q;

  // Only targets inside 0x8000-0x9FFF are VRAM; anything else is dropped.
  assign s2_in_range = (s2_tgt[15:13] == 3'b100);

  // The first write of a session is never treated as a duplicate.
  assign first_write = active_rise | ~written_any;

  assign wr_now = s2_valid & s2_in_range & (first_write | (s2_tgt != last_tgt));

  assign state_dbg = state;

  // FSM: track transfer activity and hold the CPU until the pipeline drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      cpu_stall <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (hdma_rd) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!hdma_rd) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (hdma_rd) begin
            state <= RUN;
          end else if (drain_cnt) begin
            state <= IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Stall reflects the state being entered at this ce: RUN when reading,
      // RUN->DRAIN, or the first DRAIN cycle staying in DRAIN.
      cpu_stall <= hdma_active | hdma_rd | (state == RUN) |
                   ((state == DRAIN) & ~drain_cnt);
    end
  end

  // Stage 1 and 2: register the request, then pair the returned byte with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tgt   <= 16'h0000;
      s1_bank  <= 1'b0;
      mem_addr <= 16'h0000;
      mem_rd   <= 1'b0;
      s2_valid <= 1'b0;
      s2_tgt   <= 16'h0000;
      s2_bank  <= 1'b0;
      s2_data  <= 8'h00;
    end else if (ce) begin
      // Outside a read phase (IDLE or DRAIN) stage 1 is fed invalid slots.
      s1_valid <= hdma_rd;
      mem_rd   <= hdma_rd;
      if (hdma_rd) begin
        s1_tgt   <= hdma_target_addr;
        s1_bank  <= vram_bank;
        mem_addr <= remap_src(hdma_source_addr);
      end
      s2_valid <= s1_valid;
      s2_tgt   <= s1_tgt;
      s2_bank  <= s1_bank;
      s2_data  <= mem_din;
    end
  end

  // Write stage: issue deduplicated VRAM writes and count them per session.
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_we     <= 1'b0;
      vram_addr   <= 14'h0000;
      vram_dout   <= 8'h00;
      bytes_done  <= 12'h000;
      last_tgt    <= 16'h0000;
      written_any <= 1'b0;
      active_q    <= 1'b0;
    end else if (ce) begin
      active_q <= hdma_active;
      vram_we  <= wr_now;
      if (wr_now) begin
        vram_addr   <= {s2_bank, s2_tgt[12:0]};
        vram_dout   <= s2_data;
        last_tgt    <= s2_tgt;
        written_any <= 1'b1;
      end else if (active_rise) begin
        written_any <= 1'b0;
      end
      if (active_rise) begin
        bytes_done <= wr_now ? 12'd1 : 12'd0;
      end else if (wr_now && (bytes_done != 12'hFFF)) begin
        bytes_done <= bytes_done + 12'd1;
      end
    end
  end

endmodule
